// File: rtl/clk_divisor_zero.sv
// clk_divisor_zero: down-counting prescaler that emits a one-cycle strobe every prescaler+1 enabled clocks.
module clk_divisor_zero #(
    parameter int TIMER_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [TIMER_BITS-1:0] prescaler,
    output logic                  strobe
);
    logic [TIMER_BITS-1:0] cnt;
    // Reloading at zero rather than wrapping keeps an all-ones prescaler safe from underflow.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else if (!enable) begin
            strobe <= 1'b0;
        end else if (cnt == '0) begin
            cnt    <= prescaler;
            strobe <= 1'b1;
        end else begin
            cnt    <= cnt - 1'b1;
            strobe <= 1'b0;
        end
endmodule

// File: tb/tb_clk_divisor_zero.sv
// tb_clk_divisor_zero: directed scenarios plus random enable/prescaler/reset traffic against a phase-counting model.
module tb_clk_divisor_zero;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] prescaler = '0;
    logic        strobe;
    int          errors = 0;
    int          checks = 0;
    bit          started;
    longint      per, ph;
    logic        exp_strobe;

    clk_divisor_zero #(.TIMER_BITS(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .prescaler(prescaler), .strobe(strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: count enabled edges since the last strobe; strobe when that reaches the period latched then.
    task automatic model_reset();
        started    = 1'b0;
        per        = 0;
        ph         = 0;
        exp_strobe = 1'b0;
    endtask

    function automatic longint model_cnt();
        return started ? per - ph : 0;
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        if (!enable) exp_strobe = 1'b0;
        else if (!started || ph == per) begin
            exp_strobe = 1'b1;
            per        = longint'(prescaler);
            ph         = 0;
            started    = 1'b1;
        end else begin
            exp_strobe = 1'b0;
            ph++;
        end
        #1;
        chk({tag, "_strobe"}, longint'(strobe), longint'(exp_strobe));
        chk({tag, "_cnt"}, longint'(dut.cnt), model_cnt());
    endtask

    task automatic do_reset(input int dly);
        #(dly) rst = 1'b0;
        #1 model_reset();
        chk("reset_strobe", longint'(strobe), 0);
        chk("reset_cnt", longint'(dut.cnt), 0);
        @(negedge clk) rst = 1'b1;
    endtask

    int strobe_edges[$];

    initial begin
        model_reset();
        #2;
        chk("por_strobe", longint'(strobe), 0);
        chk("por_cnt", longint'(dut.cnt), 0);
        @(negedge clk) rst = 1'b1;
        // 1: P=3 gives strobes on edges 1,5,9,13
        do_reset(0);
        prescaler = 32'd3;
        enable    = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step("p3");
            if (strobe) strobe_edges.push_back(i);
        end
        chk("p3_count", strobe_edges.size(), 4);
        for (int i = 0; i < strobe_edges.size() && i < 4; i++) chk("p3_edge", strobe_edges[i], 1 + 4 * i);
        // 2: P=0 gives a constant strobe
        do_reset(0);
        prescaler = 32'd0;
        for (int i = 0; i < 8; i++) begin
            step("p0");
            chk("p0_const", longint'(strobe), 1);
        end
        // 3: P=4 with a 3-cycle enable drop mid-countdown
        do_reset(0);
        prescaler = 32'd4;
        for (int i = 0; i < 7; i++) step("en_pre");
        enable = 1'b0;
        for (int i = 0; i < 3; i++) step("en_off");
        enable = 1'b1;
        for (int i = 0; i < 10; i++) step("en_post");
        // 4: P=2 then P=5 while cnt==1
        do_reset(0);
        prescaler = 32'd2;
        step("pchg");
        step("pchg");
        chk("pchg_cnt1", longint'(dut.cnt), 1);
        prescaler = 32'd5;
        for (int i = 0; i < 16; i++) step("pchg");
        // 5: async reset while strobe is high
        do_reset(0);
        prescaler = 32'd0;
        step("arst_pre");
        chk("arst_high", longint'(strobe), 1);
        do_reset(2);
        for (int i = 0; i < 4; i++) step("arst_post");
        // 6: all-ones prescaler, long window without a second strobe
        do_reset(0);
        prescaler = 32'hFFFF_FFFF;
        step("max_reload");
        chk("max_cnt", longint'(dut.cnt), 64'hFFFF_FFFF);
        prescaler = $urandom;
        for (int i = 0; i < 1200; i++) step("max_win");
        chk("max_dec", longint'(dut.cnt), 64'hFFFF_FFFF - 1200);
        // random traffic
        do_reset(0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset(0);
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) prescaler = $urandom_range(0, 6);
            step("rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
